bcd_scan_ctrl: RTL and testbench
================================

Name: bcd_scan_ctrl

Overview:
- Time-multiplexes one BCD-to-7-segment decoder (CD4511-style) across N_DIGITS common-cathode digits.
- Latches a packed BCD word, then steps through the digits in round-robin.
- Drives the shared 4-bit BCD bus and the blanking input, and selects one digit at a time.
- Inserts a dead-time between digits to prevent ghosting, and swaps in new values only at frame boundaries to avoid tearing.

Parameters:
- N_DIGITS, 4: number of multiplexed digits; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be greater than BLANK_CYC.
- BLANK_CYC, 2: dead cycles at the start of each slot with all digits off; must be at least 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scanning, 0 = display dark.
- value  input  4*N_DIGITS  packed BCD; digit k is value[4k+3:4k], and digit 0 is the LSD.
- load  input  1  single-cycle strobe that captures value.
- bcd_out  output  4  BCD code to the decoder input.
- blank  output  1  decoder blanking request; 1 = segments off.
- digit_en  output  N_DIGITS  one-hot digit select, active-high; all-zero when no digit is lit.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - State IDLE; slot counter, digit index, pending register and display register all 0.
  - bcd_out=0, blank=1, digit_en=0, frame_done=0.
- All outputs are registered.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - digit_en=0, blank=1.
  - enable=1 moves to BLANK with digit index 0 on the next edge.
  - load in IDLE writes value straight into the display register.
- BLANK:
  - Lasts BLANK_CYC cycles; digit_en=0, blank=1.
  - bcd_out = display nibble of the current digit index, valid from the first BLANK cycle.
  - After BLANK_CYC cycles, moves to SHOW.
- SHOW:
  - Lasts REFRESH_DIV-BLANK_CYC cycles.
  - digit_en has only bit[index] set; blank=0; bcd_out is held.
  - On the last SHOW cycle: index advances to (index+1) mod N_DIGITS and the state returns to BLANK.
  - If index was N_DIGITS-1, frame_done=1 for that cycle only.
- Slot counter: counts 0..REFRESH_DIV-1 and wraps to 0 at each slot start. Width is clog2(REFRESH_DIV).
- Loading:
  - load outside IDLE captures value into the pending register and sets pending_valid.
  - On entry to digit 0's BLANK (frame boundary), if pending_valid: display <= pending and pending_valid clears.
  - Simultaneous load on the boundary cycle: the incoming value goes straight to display, bypassing pending.
  - Multiple loads within a frame: the last one wins.
- Nibbles 10..15 are passed through unchanged; the decoder blanks them itself.
- enable falls mid-slot: next edge goes to IDLE, digit_en=0, blank=1, index reset to 0. Display and pending registers are kept.
- Reset mid-scan: all outputs go to reset values immediately, with no glitch through SHOW.
- N_DIGITS=1: digit_en stays at 1 during SHOW, and frame_done pulses every slot.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN (leading-zero blanking).
- With the macro defined:
  - During SHOW, blank=1 for any digit k>0 where digits k..N_DIGITS-1 of the display register are all zero.
  - digit_en still asserts as normal.
  - Digit 0 is never suppressed.
  - Suppression is evaluated on the display register, so it updates only at frame boundaries.
- Without the macro: blank=0 in every SHOW cycle.

Test Plan:
Bench uses N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
1. Reset behaviour:
   - Stimulus: rst=1 for 3 cycles with enable=1; then release rst.
   - Response: digit_en=0000, blank=1, bcd_out=0 during reset.
   - First BLANK begins 1 cycle after release; digit_en=0001 appears 2 cycles later.
2. Scan sequence:
   - Stimulus: load value=16'h1234 in IDLE; then enable=1.
   - Response: bcd_out cycles 4,3,2,1 with digit_en 0001,0010,0100,1000.
   - Each digit is lit for 6 cycles after 2 dark cycles.
   - frame_done pulses once every 32 cycles, on the last SHOW cycle of digit 3.
3. Tear-free update:
   - Stimulus: while digit 1 is showing, load 16'h9876.
   - Response: digits 2 and 3 still show 2 and 1.
   - Next frame shows 6,7,8,9.
4. Boundary load:
   - Stimulus: assert load with 16'h0005 on the exact frame-boundary cycle.
   - Response: 5 appears in the digit 0 slot of that same frame.
5. Enable drop:
   - Stimulus: deassert enable in the middle of digit 2's SHOW.
   - Response: next cycle digit_en=0000, blank=1.
   - Re-enabling restarts the scan at digit 0.
6. Leading-zero blanking (with BCD_SCAN_LZB_EN):
   - Stimulus: load 16'h0040.
   - Response: digits 3 and 2 have blank=1; digit 1 shows 4; digit 0 shows 0 with blank=0.
   - Without the macro: all four digits have blank=0.

Source files
------------

// File: rtl/bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_scan_ctrl
//   Time-multiplexes a single CD4511-style BCD-to-7-segment decoder across
//   N_DIGITS common-cathode digits. Each digit slot is REFRESH_DIV cycles:
//   BLANK_CYC dark cycles, which prevent ghosting, followed by the lit part of
//   the slot. A load arriving mid-frame is parked in a pending register. It
//   reaches the display register only at the next frame boundary, so a frame
//   never shows a mix of old and new digits.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   1 = scan, 0 = display dark (IDLE)
//   value      in   packed BCD, digit k = value[4k+3:4k], digit 0 = LSD
//   load       in   single-cycle strobe capturing value
//   bcd_out    out  BCD code to the decoder input
//   blank      out  decoder blanking request (1 = segments off)
//   digit_en   out  one-hot active-high digit select, 0 when dark
//   frame_done out  one-cycle pulse on the last lit cycle of the last digit
//
// Optional feature
//   BCD_SCAN_LZB_EN : leading-zero blanking. While a digit is lit, blank is
//   also raised for a digit k>0 when digits k..N_DIGITS-1 of the display
//   register are all zero. Digit 0 is never suppressed.
// ---------------------------------------------------------------------------
module bcd_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    output logic [3:0]            bcd_out,
    output logic                  blank,
    output logic [N_DIGITS-1:0]   digit_en,
    output logic                  frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [N_DIGITS-1:0][3:0]    disp_q, disp_d;
    logic [N_DIGITS-1:0][3:0]    pend_q, pend_d;
    logic                        pv_q, pv_d;
    logic [3:0]                  bcd_out_q, bcd_out_d;
    logic                        blank_q, blank_d;
    logic [N_DIGITS-1:0]         digit_en_q, digit_en_d;
    logic                        frame_done_q, frame_done_d;
    logic                        frame_start;
    logic                        suppress;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        pv_d    = pv_q;

        // Sequencing
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BLANK_CYC - 1)) state_d = SHOW;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Entering digit 0's dark phase is the frame boundary. With one digit
        // every slot is a boundary.
        frame_start = (state_d == BLANK) && (state_q != BLANK) && (idx_d == '0);

        // Display update. A direct write also drops any older pending value,
        // so the most recent load always wins.
        if (load && (state_q == IDLE || frame_start)) begin
            disp_d = value;
            pv_d   = 1'b0;
        end else if (load) begin
            pend_d = value;
            pv_d   = 1'b1;
        end else if (frame_start && pv_q) begin
            disp_d = pend_q;
            pv_d   = 1'b0;
        end

        // Outputs are computed from the next state so that they line up with
        // the state they describe once registered.
        suppress = 1'b0;
`ifdef BCD_SCAN_LZB_EN
        begin
            logic [N_DIGITS-1:0] zero_up;  // digits k..N-1 all zero
            zero_up[N_DIGITS-1] = (disp_d[N_DIGITS-1] == 4'd0);
            for (int k = N_DIGITS - 2; k >= 0; k--) begin
                zero_up[k] = (disp_d[k] == 4'd0) && zero_up[k+1];
            end
            suppress = (idx_d != '0) && zero_up[idx_d];
        end
`endif
        digit_en_d   = (state_d == SHOW) ? (N_DIGITS'(1) << idx_d) : '0;
        blank_d      = (state_d != SHOW) || suppress;
        bcd_out_d    = (state_d != IDLE) ? disp_d[idx_d] : bcd_out_q;
        frame_done_d = (state_d == SHOW) && (cnt_d == CW'(REFRESH_DIV - 1)) &&
                       (idx_d == IW'(N_DIGITS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pv_q         <= 1'b0;
            bcd_out_q    <= 4'd0;
            blank_q      <= 1'b1;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pv_q         <= pv_d;
            bcd_out_q    <= bcd_out_d;
            blank_q      <= blank_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd_out    = bcd_out_q;
    assign blank      = blank_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_ctrl
//   Scoreboard bench. The stimulus pushes one entry per expected lit digit
//   slot: digit select, code, blank and lit length. A monitor pops an entry
//   whenever a digit lights up. It then checks that entry on every lit cycle,
//   checks the lit length when the digit goes dark, and checks the position
//   of frame_done.
// ---------------------------------------------------------------------------
module tb_bcd_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
`ifdef BCD_SCAN_LZB_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic [4*N-1:0] value = '0;
    logic           load = 1'b0;
    logic [3:0]     bcd_out;
    logic           blank;
    logic [N-1:0]   digit_en;
    logic           frame_done;

    bcd_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .load(load),
        .bcd_out(bcd_out), .blank(blank), .digit_en(digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] bcd;
        logic       blk;
        int         len;
    } slot_t;

    slot_t exp_q[$];
    slot_t cur;
    int    total = 0;
    int    bad = 0;
    int    fd_cnt = 0;
    int    run = 0;
    logic [3:0] prev_en = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] en, input logic [3:0] bcd, input logic blk, input int len);
        slot_t s;
        s.en = en; s.bcd = bcd; s.blk = blk; s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (digit_en != 0 && prev_en == 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_slot", {28'd0, digit_en}, 32'd0);
                    cur.en = digit_en; cur.bcd = bcd_out; cur.blk = blank; cur.len = 0;
                end else begin
                    cur = exp_q.pop_front();
                end
                run = 1;
            end else if (digit_en != 0) begin
                run++;
            end
            if (digit_en != 0) begin
                check("slot_digit_en", {28'd0, digit_en}, {28'd0, cur.en});
                check("slot_bcd", {28'd0, bcd_out}, {28'd0, cur.bcd});
                check("slot_blank", {31'd0, blank}, {31'd0, cur.blk});
            end else begin
                check("dark_blank", {31'd0, blank}, 32'd1);
                if (prev_en != 0) check("slot_len", run, cur.len);
            end
            if (frame_done) begin
                fd_cnt++;
                check("fd_digit", {28'd0, digit_en}, 32'b1000);
                check("fd_last_cycle", run, RD - BC);
            end
            prev_en <= digit_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset behaviour
        enable = 1'b1;
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_digit_en", {28'd0, digit_en}, 32'd0);
            check("rst_blank", {31'd0, blank}, 32'd1);
            check("rst_bcd", {28'd0, bcd_out}, 32'd0);
            check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        end
        push(4'b0001, 4'd0, 1'b0, 1);
        rst = 1'b0;
        tick();  // frame cycle 0: first BLANK
        check("blank0_en", {28'd0, digit_en}, 32'd0);
        check("blank0_blank", {31'd0, blank}, 32'd1);
        tick();
        check("blank1_en", {28'd0, digit_en}, 32'd0);
        tick();
        check("first_show_en", {28'd0, digit_en}, 32'b0001);
        enable = 1'b0;
        tick();  // IDLE

        // 2. Scan sequence, two full frames of 1234
        value = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push(4'b0001, 4'd4, 1'b0, 6);
            push(4'b0010, 4'd3, 1'b0, 6);
            push(4'b0100, 4'd2, 1'b0, 6);
            push(4'b1000, 4'd1, 1'b0, 6);
        end
        tick();       // frame 1 cycle 0
        tick(32);     // frame 2 cycle 0

        // 3. Tear-free update while digit 1 is lit
        tick(12);
        value = 16'h9876; load = 1'b1;
        push(4'b0001, 4'd6, 1'b0, 6);
        push(4'b0010, 4'd7, 1'b0, 6);
        push(4'b0100, 4'd8, 1'b0, 6);
        push(4'b1000, 4'd9, 1'b0, 6);
        tick();
        load = 1'b0;
        tick(19);     // frame 3 cycle 0

        // 4. Boundary load on the last cycle of the frame
        tick(31);
        check("boundary_frame_done", {31'd0, frame_done}, 32'd1);
        value = 16'h0005; load = 1'b1;
        push(4'b0001, 4'd5, 1'b0, 6);
        push(4'b0010, 4'd0, LZB, 6);
        push(4'b0100, 4'd0, LZB, 3);
        tick();       // frame 4 cycle 0
        load = 1'b0;
        check("boundary_bcd_in_blank", {28'd0, bcd_out}, 32'd5);
        check("boundary_blank", {31'd0, blank}, 32'd1);

        // 5. Enable drop mid digit 2
        tick(20);
        enable = 1'b0;
        tick();
        check("drop_digit_en", {28'd0, digit_en}, 32'd0);
        check("drop_blank", {31'd0, blank}, 32'd1);

        // 6. Leading zeros, restart at digit 0
        value = 16'h0040; load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        push(4'b0001, 4'd0, 1'b0, 6);
        push(4'b0010, 4'd4, 1'b0, 6);
        push(4'b0100, 4'd0, LZB, 6);
        push(4'b1000, 4'd0, LZB, 6);
        tick();       // frame cycle 0
        tick(32);     // next frame's BLANK
        enable = 1'b0;
        tick(4);

        check("queue_empty", exp_q.size(), 32'd0);
        check("frame_done_count", fd_cnt, 32'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
